// File: rtl/rsfq_cell_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rsfq_cell_pkg
//  Description : Shared types and helpers for the clocked RSFQ inverter bank.
//                - lane_state_e : per-lane state (ARMED / STORED / LOCKED)
//                - OUT_NRZ/OUT_RZ : output encoding selectors
//                - sat_add      : saturating add used by the violation counter
//  Revision    : 1.0 - initial release
// ============================================================================
package rsfq_cell_pkg;

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        STORED = 2'd1,
        LOCKED = 2'd2
    } lane_state_e;

    localparam int OUT_NRZ = 0;
    localparam int OUT_RZ  = 1;

    // Adds two 32-bit values and clamps the result at max_v. The sum is formed
    // one bit wider so a 32-bit counter still saturates instead of wrapping.
    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] max_v
    );
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_v}) ? max_v : sum[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rsfq_not_lane.sv
`default_nettype none
// ============================================================================
//  Module      : rsfq_not_lane
//  Description : One clocked RSFQ inverter lane: state FSM, a-block and
//                clk-block window down-counters, DELAY_CLK_Q output pipeline.
//  Ports       : clk, rst         - sampling clock, sync active-high reset
//                a_pulse          - data pulse strobe (already warm-up gated)
//                clk_pulse        - RSFQ clock strobe (already warm-up gated)
//                err_clr          - unlocks the lane when LOCKED
//                q                - lane output (NRZ toggle or RZ pulse)
//                err              - sticky violation flag
//                viol             - one-cycle strobe for a new violation
//  Revision    : 1.0 - initial release
// ============================================================================
module rsfq_not_lane
    import rsfq_cell_pkg::*;
#(
    parameter int DELAY_CLK_Q = 6,
    parameter int CT_A_CLK    = 1,
    parameter int CT_S1_A_CLK = 2,
    parameter int CT_CLK_A    = 5,
    parameter int CT_CLK_CLK  = 5,
    parameter int OUT_MODE    = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic a_pulse,
    input  logic clk_pulse,
    input  logic err_clr,
    output logic q,
    output logic err,
    output logic viol
);

    localparam int c_WMAX_A  = (CT_A_CLK > CT_S1_A_CLK) ? CT_A_CLK : CT_S1_A_CLK;
    localparam int c_WMAX_C  = (CT_CLK_A > CT_CLK_CLK) ? CT_CLK_A : CT_CLK_CLK;
    localparam int c_WMAX    = (c_WMAX_A > c_WMAX_C) ? c_WMAX_A : c_WMAX_C;
    localparam int c_WIN_W   = (c_WMAX < 1) ? 1 : $clog2(c_WMAX + 1);

    localparam logic [c_WIN_W-1:0] c_W_A_CLK   = c_WIN_W'(CT_A_CLK);
    localparam logic [c_WIN_W-1:0] c_W_S1_A    = c_WIN_W'(CT_S1_A_CLK);
    localparam logic [c_WIN_W-1:0] c_W_CLK_A   = c_WIN_W'(CT_CLK_A);
    localparam logic [c_WIN_W-1:0] c_W_CLK_CLK = c_WIN_W'(CT_CLK_CLK);
    localparam logic [c_WIN_W-1:0] c_ONE       = c_WIN_W'(1);

    lane_state_e            r_state;
    lane_state_e            w_state_nxt;
    logic [c_WIN_W-1:0]     r_a_blk;
    logic [c_WIN_W-1:0]     r_c_blk;
    logic [c_WIN_W-1:0]     w_a_dec;
    logic [c_WIN_W-1:0]     w_c_dec;
    logic [c_WIN_W-1:0]     w_a_nxt;
    logic [c_WIN_W-1:0]     w_c_nxt;
    logic                   w_a_act;
    logic                   w_c_act;
    logic                   w_viol;
    logic                   w_fire;
    logic                   w_ev;
    logic [DELAY_CLK_Q-1:0] r_pipe;
    logic                   r_q;
    logic                   r_err;

    // A restarted window keeps whichever end lies further in the future.
    function automatic logic [c_WIN_W-1:0] win_max(
        input logic [c_WIN_W-1:0] x,
        input logic [c_WIN_W-1:0] y
    );
        return (x > y) ? x : y;
    endfunction

    // A counter value of n means the current cycle and n-1 more are blocked.
    assign w_a_act = |r_a_blk;
    assign w_c_act = |r_c_blk;
    assign w_a_dec = w_a_act ? (r_a_blk - c_ONE) : '0;
    assign w_c_dec = w_c_act ? (r_c_blk - c_ONE) : '0;

    // Coincident a/clk is always a violation; otherwise each pulse is checked
    // against the window that blocks it. LOCKED lanes never report.
    assign w_viol = (r_state != LOCKED) &&
                    ((a_pulse && clk_pulse) ||
                     (a_pulse && w_a_act)   ||
                     (clk_pulse && w_c_act));

    // Only a clock arriving in ARMED produces an output event.
    assign w_fire = (r_state == ARMED) && clk_pulse && !w_viol;
    assign w_ev   = r_pipe[DELAY_CLK_Q-1];

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = w_a_dec;
        w_c_nxt     = w_c_dec;
        case (r_state)
            LOCKED: begin
                if (err_clr) begin
                    w_state_nxt = ARMED;
                    w_a_nxt     = '0;
                    w_c_nxt     = '0;
                end
            end
            ARMED, STORED: begin
                if (w_viol) begin
                    w_state_nxt = LOCKED;
                end else if (a_pulse) begin
                    w_state_nxt = STORED;
                    w_c_nxt     = win_max(w_c_dec,
                                          (r_state == ARMED) ? c_W_A_CLK : c_W_S1_A);
                end else if (clk_pulse) begin
                    if (r_state == ARMED) begin
                        w_a_nxt = win_max(w_a_dec, c_W_CLK_A);
                        w_c_nxt = win_max(w_c_dec, c_W_CLK_CLK);
                    end else begin
                        w_state_nxt = ARMED;
                    end
                end
            end
            default: begin
                w_state_nxt = ARMED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARMED;
            r_a_blk <= '0;
            r_c_blk <= '0;
            r_pipe  <= '0;
            r_q     <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a_blk <= w_a_nxt;
            r_c_blk <= w_c_nxt;
            if (w_viol) begin
                // Violation cancels everything in flight, including an event
                // that would have landed in this very cycle.
                r_pipe <= '0;
                r_q    <= 1'b0;
                r_err  <= 1'b1;
            end else begin
                r_pipe <= (r_pipe << 1) | DELAY_CLK_Q'(w_fire);
                if (OUT_MODE == OUT_NRZ) begin
                    if (w_ev) begin
                        r_q <= ~r_q;
                    end
                end else begin
                    r_q <= w_ev;
                end
                if (err_clr && (r_state == LOCKED)) begin
                    r_err <= 1'b0;
                end
            end
        end
    end

    assign q    = r_q;
    assign err  = r_err;
    assign viol = w_viol;

endmodule
`default_nettype wire

// File: rtl/rsfq_not_array_tc.sv
`default_nettype none
// ============================================================================
//  Module      : rsfq_not_array_tc
//  Description : N-lane bank of clocked RSFQ inverters with shared clk_pulse,
//                warm-up masking, sticky per-lane errors and a saturating
//                violation counter.
//  Ports       : clk, rst   - sampling clock, sync active-high reset
//                a_pulse    - per-lane data strobes [N_LANES]
//                clk_pulse  - shared RSFQ clock strobe
//                err_clr    - clears err[] and unlocks errored lanes
//                q          - per-lane outputs [N_LANES]
//                err        - sticky per-lane violation flags [N_LANES]
//                viol_cnt   - total violations, saturating [CNT_W]
//                ready      - high once warm-up has elapsed
//  Revision    : 1.0 - initial release
// ============================================================================
module rsfq_not_array_tc
    import rsfq_cell_pkg::*;
#(
    parameter int N_LANES     = 4,
    parameter int DELAY_CLK_Q = 6,
    parameter int CT_A_CLK    = 1,
    parameter int CT_S1_A_CLK = 2,
    parameter int CT_CLK_A    = 5,
    parameter int CT_CLK_CLK  = 5,
    parameter int OUT_MODE    = 0,
    parameter int WARMUP      = 4,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_LANES-1:0] a_pulse,
    input  logic               clk_pulse,
    input  logic               err_clr,
    output logic [N_LANES-1:0] q,
    output logic [N_LANES-1:0] err,
    output logic [CNT_W-1:0]   viol_cnt,
    output logic               ready
);

    localparam int c_WARM_W = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
    localparam logic [c_WARM_W-1:0] c_WARM_MAX = c_WARM_W'(WARMUP);
    localparam int c_POP_W  = $clog2(N_LANES + 1);
    localparam logic [31:0] c_CNT_MAX = (CNT_W >= 32) ? 32'hFFFF_FFFF
                                                       : ((32'd1 << CNT_W) - 32'd1);

    logic [c_WARM_W-1:0] r_warm_cnt;
    logic                r_ready;
    logic                w_live;
    logic [N_LANES-1:0]  w_a_gated;
    logic                w_clk_gated;
    logic [N_LANES-1:0]  w_viol;
    logic [c_POP_W-1:0]  w_pop;
    logic [CNT_W-1:0]    r_viol_cnt;

    // Pulses are accepted once WARMUP non-reset cycles have gone by; ready is
    // the registered view of that, so it rises the cycle a first pulse could
    // take effect.
    assign w_live      = (r_warm_cnt == c_WARM_MAX);
    assign w_a_gated   = w_live ? a_pulse : '0;
    assign w_clk_gated = w_live & clk_pulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_warm_cnt <= '0;
            r_ready    <= 1'b0;
        end else begin
            if (!w_live) begin
                r_warm_cnt <= r_warm_cnt + c_WARM_W'(1);
            end
            r_ready <= w_live;
        end
    end

    generate
        for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
            rsfq_not_lane #(
                .DELAY_CLK_Q (DELAY_CLK_Q),
                .CT_A_CLK    (CT_A_CLK),
                .CT_S1_A_CLK (CT_S1_A_CLK),
                .CT_CLK_A    (CT_CLK_A),
                .CT_CLK_CLK  (CT_CLK_CLK),
                .OUT_MODE    (OUT_MODE)
            ) u_lane (
                .clk       (clk),
                .rst       (rst),
                .a_pulse   (w_a_gated[gi]),
                .clk_pulse (w_clk_gated),
                .err_clr   (err_clr),
                .q         (q[gi]),
                .err       (err[gi]),
                .viol      (w_viol[gi])
            );
        end
    endgenerate

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_LANES; i++) begin
            w_pop = w_pop + c_POP_W'(w_viol[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_viol_cnt <= '0;
        end else begin
            r_viol_cnt <= CNT_W'(sat_add(32'(r_viol_cnt), 32'(w_pop), c_CNT_MAX));
        end
    end

    assign viol_cnt = r_viol_cnt;
    assign ready    = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_rsfq_not_array_tc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rsfq_not_array_tc
//  Description : Self-checking bench for rsfq_not_array_tc. Two instances
//                share one stimulus stream: defaults (NRZ, 16-bit counter)
//                and RZ output with a 2-bit counter. A time-based reference
//                model is compared every cycle; literal checks pin key points.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rsfq_not_array_tc;

    localparam int NL   = 4;
    localparam int D    = 6;
    localparam int CTA  = 1;
    localparam int CTS  = 2;
    localparam int CTCA = 5;
    localparam int CTCC = 5;
    localparam int WU   = 4;
    localparam int CAL  = 256;
    localparam int c_MODE [2]   = '{0, 1};
    localparam int c_CNTMAX [2] = '{65535, 3};

    // model lane states
    localparam int M_ARMED  = 0;
    localparam int M_STORED = 1;
    localparam int M_LOCKED = 2;

    logic          clk;
    logic          rst;
    logic [NL-1:0] a_pulse;
    logic          clk_pulse;
    logic          err_clr;
    logic [NL-1:0] q_a, err_a, q_b, err_b;
    logic [15:0]   cnt_a;
    logic [1:0]    cnt_b;
    logic          ready_a, ready_b;

    int n_checks = 0;
    int n_errors = 0;
    int t = 0;

    rsfq_not_array_tc u_dut_a (
        .clk(clk), .rst(rst), .a_pulse(a_pulse), .clk_pulse(clk_pulse),
        .err_clr(err_clr), .q(q_a), .err(err_a), .viol_cnt(cnt_a), .ready(ready_a)
    );

    rsfq_not_array_tc #(.OUT_MODE(1), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .a_pulse(a_pulse), .clk_pulse(clk_pulse),
        .err_clr(err_clr), .q(q_b), .err(err_b), .viol_cnt(cnt_b), .ready(ready_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: windows kept as absolute "blocked through" cycle
    // numbers, output events kept in a calendar indexed by due cycle.
    // ------------------------------------------------------------------
    int  mk;
    bit  mvalid = 1'b0;
    int  ms   [2][NL];
    int  mau  [2][NL];
    int  mcu  [2][NL];
    bit  mq   [2][NL];
    bit  merr [2][NL];
    bit  mdue [2][NL][CAL];
    int  mcnt [2];
    bit  mready;

    always @(posedge clk) begin : p_model
        int nv;
        bit live, av, cv, due, viol;
        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < NL; i++) begin
                    ms[m][i] = M_ARMED; mau[m][i] = -1; mcu[m][i] = -1;
                    mq[m][i] = 1'b0; merr[m][i] = 1'b0;
                    for (int c = 0; c < CAL; c++) mdue[m][i][c] = 1'b0;
                end
                mcnt[m] = 0;
            end
            mready = 1'b0;
            mk     = 0;
            mvalid = 1'b1;
        end else begin
            live = (mk >= WU);
            for (int m = 0; m < 2; m++) begin
                nv = 0;
                for (int i = 0; i < NL; i++) begin
                    av  = live && a_pulse[i];
                    cv  = live && clk_pulse;
                    due = mdue[m][i][mk % CAL];
                    mdue[m][i][mk % CAL] = 1'b0;
                    if (c_MODE[m] == 1) mq[m][i] = 1'b0;
                    if (ms[m][i] == M_LOCKED) begin
                        if (err_clr) begin
                            ms[m][i] = M_ARMED; mau[m][i] = -1; mcu[m][i] = -1;
                            merr[m][i] = 1'b0;
                        end
                    end else begin
                        viol = (av && cv) || (av && mk <= mau[m][i]) ||
                               (cv && mk <= mcu[m][i]);
                        if (viol) begin
                            ms[m][i] = M_LOCKED; merr[m][i] = 1'b1; mq[m][i] = 1'b0;
                            for (int c = 0; c < CAL; c++) mdue[m][i][c] = 1'b0;
                            nv++;
                        end else begin
                            if (due) mq[m][i] = (c_MODE[m] == 1) ? 1'b1 : ~mq[m][i];
                            if (av) begin
                                if (ms[m][i] == M_ARMED)
                                    mcu[m][i] = (mcu[m][i] > mk + CTA) ? mcu[m][i] : mk + CTA;
                                else
                                    mcu[m][i] = (mcu[m][i] > mk + CTS) ? mcu[m][i] : mk + CTS;
                                ms[m][i] = M_STORED;
                            end else if (cv) begin
                                if (ms[m][i] == M_ARMED) begin
                                    mdue[m][i][(mk + D) % CAL] = 1'b1;
                                    mau[m][i] = (mau[m][i] > mk + CTCA) ? mau[m][i] : mk + CTCA;
                                    mcu[m][i] = (mcu[m][i] > mk + CTCC) ? mcu[m][i] : mk + CTCC;
                                end else begin
                                    ms[m][i] = M_ARMED;
                                end
                            end
                        end
                    end
                end
                mcnt[m] = (mcnt[m] + nv > c_CNTMAX[m]) ? c_CNTMAX[m] : mcnt[m] + nv;
            end
            mready = live;
            mk++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0d actual=%0h expected=%0h", name, t, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin : p_compare
        logic [NL-1:0] eq, ee;
        if (mvalid) begin
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < NL; i++) begin
                    eq[i] = mq[m][i];
                    ee[i] = merr[m][i];
                end
                chk($sformatf("inst%0d_q", m),     32'((m == 0) ? q_a : q_b), 32'(eq));
                chk($sformatf("inst%0d_err", m),   32'((m == 0) ? err_a : err_b), 32'(ee));
                chk($sformatf("inst%0d_cnt", m),   (m == 0) ? 32'(cnt_a) : 32'(cnt_b), 32'(mcnt[m]));
                chk($sformatf("inst%0d_ready", m), 32'((m == 0) ? ready_a : ready_b), 32'(mready));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: cycle t is sampled at the t-th posedge after reset
    // release; obs_at(T) returns just after posedge T.
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        t++;
    endtask

    task automatic idle_to(input int target);
        while (t < target) step();
    endtask

    task automatic pulse(input int at, input logic [NL-1:0] a, input logic c, input logic clr);
        idle_to(at);
        a_pulse = a; clk_pulse = c; err_clr = clr;
        step();
        a_pulse = '0; clk_pulse = 1'b0; err_clr = 1'b0;
    endtask

    task automatic obs_at(input int at);
        idle_to(at + 1);
    endtask

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog t=%0d actual=running expected=finished", t);
        $fatal(1, "timeout");
    end

    initial begin : p_drive
        rst = 1'b1; a_pulse = '0; clk_pulse = 1'b0; err_clr = 1'b0;
        @(negedge clk);
        repeat (3) step();
        chk("reset_q", 32'(q_a), 32'h0);
        chk("reset_cnt", 32'(cnt_a), 32'h0);
        chk("reset_ready", 32'(ready_a), 32'h0);
        rst = 1'b0;
        t = 0;

        // basic inversion, both encodings
        pulse(10, 4'b0000, 1'b1, 1'b0);
        obs_at(15); chk("q15_nrz", 32'(q_a), 32'h0); chk("q15_rz", 32'(q_b), 32'h0);
        obs_at(16); chk("q16_nrz", 32'(q_a), 32'hF); chk("q16_rz", 32'(q_b), 32'hF);
        chk("err16", 32'(err_a), 32'h0); chk("cnt16", 32'(cnt_a), 32'h0);
        obs_at(17); chk("q17_nrz", 32'(q_a), 32'hF); chk("q17_rz", 32'(q_b), 32'h0);

        // stored data suppresses the output on lane 1
        pulse(20, 4'b0010, 1'b0, 1'b0);
        pulse(25, 4'b0000, 1'b1, 1'b0);
        obs_at(31); chk("q31", 32'(q_a), 32'h2);
        pulse(40, 4'b0000, 1'b1, 1'b0);
        obs_at(46); chk("q46", 32'(q_a), 32'hD);

        // a inside the clk->a window locks lane 2
        pulse(50, 4'b0000, 1'b1, 1'b0);
        pulse(53, 4'b0100, 1'b0, 1'b0);
        obs_at(53); chk("err53", 32'(err_a), 32'h4); chk("cnt53", 32'(cnt_a), 32'h1);
        chk("q53", 32'(q_a), 32'h9);
        obs_at(56); chk("q56", 32'(q_a), 32'h2);
        pulse(60, 4'b0000, 1'b1, 1'b0);
        obs_at(66); chk("q66", 32'(q_a), 32'h9); chk("err66", 32'(err_a), 32'h4);
        pulse(70, 4'b0000, 1'b0, 1'b1);
        obs_at(70); chk("err70", 32'(err_a), 32'h0);

        // clk inside the clk->clk window on every lane; counter saturation
        pulse(80, 4'b0000, 1'b1, 1'b0);
        pulse(83, 4'b0000, 1'b1, 1'b0);
        obs_at(83); chk("err83", 32'(err_a), 32'hF); chk("cnt83", 32'(cnt_a), 32'd5);
        chk("cnt83_sat", 32'(cnt_b), 32'd3); chk("model_cnt83", 32'(mcnt[0]), 32'd5);
        obs_at(86); chk("q86", 32'(q_a), 32'h0);

        // coincident a and clk on lane 0
        pulse(90, 4'b0000, 1'b0, 1'b1);
        pulse(95, 4'b0001, 1'b1, 1'b0);
        obs_at(95); chk("err95", 32'(err_a), 32'h1); chk("cnt95", 32'(cnt_a), 32'd6);
        obs_at(101); chk("q101", 32'(q_a), 32'hE);

        // STORED + a opens the longer a->clk window
        pulse(110, 4'b1000, 1'b0, 1'b0);
        pulse(112, 4'b1000, 1'b0, 1'b0);
        pulse(114, 4'b0000, 1'b1, 1'b0);
        obs_at(114); chk("err114", 32'(err_a), 32'h9); chk("cnt114", 32'(cnt_a), 32'd7);
        chk("q114", 32'(q_a), 32'h6);

        // last blocked cycle versus first free cycle of the clk->a window
        pulse(120, 4'b0000, 1'b1, 1'b0);
        obs_at(120); chk("q120", 32'(q_a), 32'h0);
        pulse(125, 4'b0010, 1'b0, 1'b0);
        pulse(126, 4'b0100, 1'b0, 1'b0);
        obs_at(126); chk("err126", 32'(err_a), 32'hB); chk("cnt126", 32'(cnt_a), 32'd8);
        chk("q126", 32'(q_a), 32'h4); chk("model_q126", 32'(mq[0][2]), 32'h1);

        // warm-up masking and reset discarding a pending event
        idle_to(130);
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        t = 0;
        pulse(2, 4'b0001, 1'b0, 1'b0);
        obs_at(3); chk("ready3", 32'(ready_a), 32'h0);
        pulse(4, 4'b0000, 1'b1, 1'b0);
        chk("ready4", 32'(ready_a), 32'h1); chk("ready4_b", 32'(ready_b), 32'h1);
        obs_at(10); chk("q10_after_warmup", 32'(q_a), 32'hF);
        pulse(10, 4'b0000, 1'b1, 1'b0);
        idle_to(13);
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        obs_at(16); chk("q16_after_rst", 32'(q_a), 32'h0);
        chk("q16_after_rst_b", 32'(q_b), 32'h0); chk("ready16", 32'(ready_a), 32'h0);
        idle_to(25);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
